// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg: funct3 codes, alu_function bit positions and FSM encoding shared by the ALU and its decoder
package riscv_alu_pkg;
  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SHIFTR  = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;
  localparam int FN_WORD      = 4;
  localparam int FN_SECONDARY = 3;
  localparam int FN_F3_MSB    = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: iterative 64-bit shifter moving up to SHIFT_STEP bits per cycle
module alu_shift_unit #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        left_i,
  input  logic        fill_i,
  input  logic [63:0] value_i,
  input  logic [5:0]  amount_i,
  output logic [63:0] next_o,
  output logic        last_o
);
  localparam logic [5:0] STEP = 6'(SHIFT_STEP);
  logic [63:0] value_q, value_d;
  logic [5:0]  cnt_q, cnt_d, step;
  logic        left_q, fill_q;
  always_comb begin
    step = cnt_q < STEP ? cnt_q : STEP;
    value_d = left_q ? value_q << step : 64'({{64{fill_q}}, value_q} >> step);
    cnt_d = cnt_q - step;
    last_o = cnt_q != 6'd0 && cnt_d == 6'd0;
    next_o = value_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else if (load_i) begin
      value_q <= value_i;
      cnt_q   <= amount_i;
      left_q  <= left_i;
      fill_q  <= fill_i;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: RV64 integer ALU with single-cycle logic/arith and iterative shifts behind a valid/ready handshake
import riscv_alu_pkg::*;
module alu_multicycle #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_function,
  input  logic [63:0] operand_a,
  input  logic [63:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        zero
);
  state_t      state_q;
  logic [63:0] result_q, res_c, sum, sh_load, sh_next, sh_fin;
  logic [5:0]  amt;
  logic [2:0]  f3;
  logic        out_valid_q, zero_q, word_q;
  logic        sec, is_shift, word_op, sh_left, sh_fill, sh_last, accept, multi;
  always_comb begin
    f3 = alu_function[FN_F3_MSB:0];
    sec = alu_function[FN_SECONDARY];
    is_shift = f3 == ALU_SLL || f3 == ALU_SHIFTR;
    word_op = alu_function[FN_WORD] && (is_shift || f3 == ALU_ADD_SUB);
    amt = word_op ? {1'b0, operand_b[4:0]} : operand_b[5:0];
    sum = sec ? operand_a - operand_b : operand_a + operand_b;
    case (f3)
      ALU_ADD_SUB: res_c = word_op ? sext32(sum[31:0]) : sum;
      ALU_SLT:     res_c = {63'd0, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU:    res_c = {63'd0, operand_a < operand_b};
      ALU_XOR:     res_c = operand_a ^ operand_b;
      ALU_OR:      res_c = operand_a | operand_b;
      ALU_AND:     res_c = operand_a & operand_b;
      default:     res_c = word_op ? sext32(operand_a[31:0]) : operand_a;
    endcase
    // word right shifts run on a 64-bit pre-extended value so only the low half matters
    sh_left = f3 == ALU_SLL;
    sh_fill = !sh_left && sec && (word_op ? operand_a[31] : operand_a[63]);
    sh_load = !sh_left && word_op ? {{32{sh_fill}}, operand_a[31:0]} : operand_a;
    sh_fin = word_q ? sext32(sh_next[31:0]) : sh_next;
    in_ready = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
    accept = in_valid && in_ready;
    multi = is_shift && amt != 6'd0;
  end
  alu_shift_unit #(.SHIFT_STEP(SHIFT_STEP)) u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(accept && multi),
    .left_i(sh_left),
    .fill_i(sh_fill),
    .value_i(sh_load),
    .amount_i(amt),
    .next_o(sh_next),
    .last_o(sh_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      word_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            word_q <= word_op;
            if (multi) begin
              state_q     <= SHIFT;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_c;
              zero_q      <= res_c == 64'd0;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh_last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= sh_fin;
            zero_q      <= sh_fin == 64'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with hand-computed results and latencies for alu_multicycle
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_function = '0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        zero;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[8];

  alu_multicycle dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_function(alu_function),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] r, input int l);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    alu_function = f;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_latency"}, 64'(lat), 64'(l));
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, zero, r == 64'd0);
  endtask

  initial begin
    bit seen;
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 64'd0);
    check("rst_zero", zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    run_op("sub_neg", 5'b01000, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run_op("add", 5'b00000, 64'd5, 64'd7, 64'd12, 1);
    run_op("add_wrap", 5'b00000, '1, 64'd1, 64'd0, 1);
    run_op("sraw", 5'b11101, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 5);
    run_op("sub_zero", 5'b01000, 64'h1234, 64'h1234, 64'd0, 1);
    run_op("sltu", 5'b00011, 64'd1, '1, 64'd1, 1);
    run_op("slt_true", 5'b00010, '1, 64'd1, 64'd1, 1);
    run_op("slt_sec_false", 5'b01010, 64'd1, '1, 64'd0, 1);
    run_op("sll63", 5'b00001, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 64);
    run_op("srl", 5'b00101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 5);
    run_op("sra", 5'b01101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 5);
    run_op("srlw", 5'b10101, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 5);
    run_op("sllw_b63", 5'b10001, 64'd1, 64'd63, 64'hFFFF_FFFF_8000_0000, 32);
    run_op("addw_wrap", 5'b10000, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("xor_word_ign", 5'b10100, 64'hF0F0_0000_0000_00FF, 64'hFF, 64'hF0F0_0000_0000_0000, 1);
    run_op("or_sec_ign", 5'b01110, 64'hF0, 64'h0F, 64'hFF, 1);
    run_op("and", 5'b00111, 64'hF0, 64'h3C, 64'h30, 1);
    run_op("sll_amt0", 5'b00001, 64'h1234, 64'd64, 64'h1234, 1);

    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_function = 5'b00000;
    operand_a = 64'd3;
    operand_b = 64'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    operand_a = 64'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_result", result, 64'd7);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_function = 5'b00100;
    operand_a = 64'hFF;
    operand_b = 64'h0F;
    #1 check("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_result", result, 64'hF0);

    @(negedge clk);
    in_valid = 1'b1;
    alu_function = 5'b00001;
    operand_a = 64'd1;
    operand_b = 64'd63;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_shift_valid", out_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_zero", zero, 1'b1);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_result_after_rst", seen, 1'b0);

    for (int i = 0; i < 8; i++) exp_q[i] = (64'h1111 * 64'(i + 1)) ^ 64'h00FF_00FF;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_result", result, exp_q[i-1]);
      end
      if (i < 8) begin
        check("b2b_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        alu_function = 5'b00100;
        operand_a = 64'h1111 * 64'(i + 1);
        operand_b = 64'h00FF_00FF;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_drained", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The module SHALL have parameter SHIFT_STEP, default 1, giving the shift distance per cycle; legal values are 1, 2, 4 and 8.
REQ-002 The module SHALL have input port clk, 1 bit, the sole clock, rising-edge.
REQ-003 The module SHALL have input port rst_n, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have input port in_valid, 1 bit, marking an operation request.
REQ-005 The module SHALL have output port in_ready, 1 bit, meaning the module accepts a request this cycle.
REQ-006 The module SHALL have input port alu_function, 5 bits, encoded {word, secondary, funct3}.
REQ-007 The module SHALL have input ports operand_a and operand_b, 64 bits each, the source operands.
REQ-008 The module SHALL have output port out_valid, 1 bit, marking a valid result.
REQ-009 The module SHALL have input port out_ready, 1 bit, meaning the consumer takes the result.
REQ-010 The module SHALL have output port result, 64 bits, the operation result.
REQ-011 The module SHALL have output port zero, 1 bit, set when result equals 0 (used for BEQ/BNE).

Function
REQ-012 A request SHALL transfer on a rising clk edge when in_valid and in_ready are both high; alu_function and the operands SHALL be captured on that edge.
REQ-013 funct3 decode SHALL be: 000 ADD (SUB when secondary=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when secondary=1), 110 OR, 111 AND.
REQ-014 The secondary bit SHALL be ignored for all funct3 values except 000 and 101.
REQ-015 For word=1 with funct3 000, 001 or 101, the operation SHALL use operand_a[31:0], and result SHALL be the 32-bit result sign-extended from bit 31.
REQ-016 For word=1 with any other funct3, the word bit SHALL be ignored and the full 64-bit operation performed.
REQ-017 SLT and SLTU SHALL return 64'd1 when true and 64'd0 when false.
REQ-018 Shift amount SHALL be operand_b[5:0] for 64-bit shifts and operand_b[4:0] for word shifts.
REQ-019 For word SRA, vacated bits SHALL be filled with operand_a[31]; for word SRL, they SHALL be filled with 0.
REQ-020 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-021 In IDLE, in_ready SHALL be 1.
REQ-022 On acceptance of a non-shift operation, or of a shift with amount 0, the state SHALL go to DONE, so that out_valid is high on the next cycle (latency 1).
REQ-023 On acceptance of a shift with amount N > 0, the state SHALL go to SHIFT.
REQ-024 In SHIFT, the working value SHALL move min(SHIFT_STEP, remaining) bits per cycle.
REQ-025 When remaining reaches 0, the state SHALL go to DONE; total latency SHALL be ceil(N/SHIFT_STEP)+1 cycles.
REQ-026 In SHIFT, in_ready SHALL be 0.
REQ-027 In DONE, out_valid SHALL be 1.
REQ-028 While out_valid=1 and out_ready=0, result and zero SHALL hold stable.
REQ-029 In DONE with out_ready=1, in_ready SHALL be 1 (combinational from out_ready), and a simultaneous new request SHALL be accepted on the same edge, sustaining one non-shift operation per cycle.
REQ-030 In DONE with out_ready=1 and no new request, the state SHALL return to IDLE.
REQ-031 zero SHALL be computed from the final 64-bit result.
REQ-032 Arithmetic SHALL wrap modulo 2^64, or modulo 2^32 before sign-extension for word ops; no overflow flag SHALL exist.

Reset
REQ-033 Assertion of rst_n low SHALL immediately force state to IDLE, out_valid to 0, result to 0, zero to 1 and the shift counter to 0.
REQ-034 While rst_n is low, in_ready SHALL be 0; it SHALL become 1 in the first cycle after deassertion.
REQ-035 A reset during SHIFT or DONE SHALL discard the operation with no result delivered.

Structure
REQ-036 Package riscv_alu_pkg SHALL hold the funct3 constants (ALU_ADD_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SHIFTR, ALU_OR, ALU_AND), the alu_function bit positions, and the state encoding, shared with the ALU control decoder.
REQ-037 The iterative shifter (operand, counter, fill bit, direction) SHALL be sub-module alu_shift_unit; all other arithmetic SHALL be inline.

Verification
REQ-038 ADD/SUB: fn=5'b01000, a=5, b=7 -> result 64'hFFFF_FFFF_FFFF_FFFE, zero=0, out_valid high 1 cycle after accept.
REQ-039 Word SRA: fn=5'b11101, a=64'h0000_0000_8000_0000, b=4, SHIFT_STEP=1 -> result 64'hFFFF_FFFF_F800_0000, out_valid 5 cycles after accept.
REQ-040 Zero flag: fn=5'b01000 (SUB), a=b=64'h1234 -> result 0, zero=1; SLTU with a=1, b=64'hFFFF_FFFF_FFFF_FFFF -> result 1.
REQ-041 Backpressure: hold out_ready=0 for 3 cycles after DONE -> result stable and in_ready=0; then raise out_ready with in_valid=1 -> next op accepted on the same edge.
REQ-042 Reset mid-shift: SLL with b=63, assert rst_n low at cycle 10 -> out_valid=0 and result=0 immediately; no result appears after release.
REQ-043 Back-to-back: 8 consecutive XOR requests with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
